// File: rtl/lg_nor_bist_ctrl.sv
// Built-in self-test sequencer for the six-input NOR gate block.
// The sequencer steps through all 64 input vectors and holds each one for a
// programmable settle time. It then samples the four gate outputs against
// an internal NOR model and records the error count and the first failing
// vector.
module lg_nor_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] vec,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [5:0] first_fail_vec,
  output logic [3:0] first_fail_y
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } stateT;

  // Last settle count before the sample cycle; legal parameter range is 1..15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  stateT      state_q, state_d;
  logic [3:0] settleCnt_q, settleCnt_d;
  logic [5:0] vec_q, vec_d;
  logic [6:0] errCount_q, errCount_d;
  logic [5:0] failVec_q, failVec_d;
  logic [3:0] failY_q, failY_d;
  logic       failSeen_q, failSeen_d;

  logic [3:0] expY;
  logic       mismatch;

  // Ideal NOR response for the current vector; G (vec[0]) never contributes.
  always_comb begin
    expY[0]  = ~(|vec_q[5:4]);
    expY[1]  = ~(|vec_q[5:3]);
    expY[2]  = ~(|vec_q[5:2]);
    expY[3]  = ~(|vec_q[5:1]);
    mismatch = (y_in != expY);
  end

  // Next-state logic: sweep control, abort handling and result capture.
  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    vec_d       = vec_q;
    errCount_d  = errCount_q;
    failVec_d   = failVec_q;
    failY_d     = failY_q;
    failSeen_d  = failSeen_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          settleCnt_d = 4'd0;
          vec_d       = 6'd0;
          errCount_d  = 7'd0;
          failVec_d   = 6'd0;
          failY_d     = 4'd0;
          failSeen_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d     = IDLE;
          vec_d       = 6'd0;
          settleCnt_d = 4'd0;
        end else begin
          settleCnt_d = settleCnt_q + 4'd1;
          if (settleCnt_q == SETTLE_LAST) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (abort) begin
          state_d     = IDLE;
          vec_d       = 6'd0;
          settleCnt_d = 4'd0;
        end else begin
          if (mismatch) begin
            errCount_d = errCount_q + 7'd1;
            if (!failSeen_q) begin
              failSeen_d = 1'b1;
              failVec_d  = vec_q;
              failY_d    = y_in;
            end
          end
          if (vec_q == 6'd63) begin
            state_d = DONE;
          end else begin
            vec_d       = vec_q + 6'd1;
            settleCnt_d = 4'd0;
            state_d     = SETTLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settleCnt_q <= 4'd0;
      vec_q       <= 6'd0;
      errCount_q  <= 7'd0;
      failVec_q   <= 6'd0;
      failY_q     <= 4'd0;
      failSeen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      vec_q       <= vec_d;
      errCount_q  <= errCount_d;
      failVec_q   <= failVec_d;
      failY_q     <= failY_d;
      failSeen_q  <= failSeen_d;
    end
  end

  assign vec            = vec_q;
  assign busy           = (state_q == SETTLE) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = done && (errCount_q == 7'd0);
  assign err_count      = errCount_q;
  assign first_fail_vec = failVec_q;
  assign first_fail_y   = failY_q;

endmodule

// File: tb/tb_lg_nor_bist_ctrl.sv
// Testbench for lg_nor_bist_ctrl. Two instances are used: one with the
// default settle time and one with SETTLE_CYCLES=1. A scoreboard queue
// holds the expected result of each completed run, and a monitor checks
// that result whenever a done output rises.
module tb_lg_nor_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic       startS [2];
  logic       abortS [2];
  logic [5:0] vecS   [2];
  logic [3:0] yIn    [2];
  logic       busyS  [2];
  logic       doneS  [2];
  logic       passS  [2];
  logic [6:0] errS   [2];
  logic [5:0] ffvS   [2];
  logic [3:0] ffyS   [2];
  int         faultMode [2];

  int total = 0;
  int bad = 0;
  int cycleCount = 0;

  typedef struct {
    int id;
    int errCount;
    int ffv;
    int ffy;
    int pass;
    int latency;
  } ExpT;

  ExpT expQ[$];
  ExpT monE;

  logic       prevBusy  [2];
  logic       prevDone  [2];
  logic [5:0] prevVec   [2];
  int         startCyc  [2];
  int         stepCount [2];
  int         orderBad  [2];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Gate block model: mode 0 ideal, 1 Y4 stuck-at-0, 2 Y1 stuck-at-1.
  function automatic logic [3:0] gateModel(logic [5:0] v, int mode);
    logic [3:0] y;
    y[0] = ~(v[5] | v[4]);
    y[1] = ~(v[5] | v[4] | v[3]);
    y[2] = ~(v[5] | v[4] | v[3] | v[2]);
    y[3] = ~(v[5] | v[4] | v[3] | v[2] | v[1]);
    case (mode)
      1: y[3] = 1'b0;
      2: y[0] = 1'b1;
      default: ;
    endcase
    return y;
  endfunction

  assign yIn[0] = gateModel(vecS[0], faultMode[0]);
  assign yIn[1] = gateModel(vecS[1], faultMode[1]);

  lg_nor_bist_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(startS[0]), .abort(abortS[0]),
    .vec(vecS[0]), .y_in(yIn[0]), .busy(busyS[0]), .done(doneS[0]),
    .pass(passS[0]), .err_count(errS[0]), .first_fail_vec(ffvS[0]),
    .first_fail_y(ffyS[0])
  );

  lg_nor_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(startS[1]), .abort(abortS[1]),
    .vec(vecS[1]), .y_in(yIn[1]), .busy(busyS[1]), .done(doneS[1]),
    .pass(passS[1]), .err_count(errS[1]), .first_fail_vec(ffvS[1]),
    .first_fail_y(ffyS[1])
  );

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issue a start pulse. When the run is expected to complete, its result is pushed first.
  task automatic applyStimulus(int k, int mode, bit expectDone, int eErr, int eFfv,
                               int eFfy, int ePass, int eLat);
    ExpT e;
    faultMode[k] = mode;
    if (expectDone) begin
      e = '{k, eErr, eFfv, eFfy, ePass, eLat};
      expQ.push_back(e);
    end
    @(negedge clk) startS[k] = 1'b1;
    @(negedge clk) startS[k] = 1'b0;
  endtask

  task automatic waitDone(int k, int limit);
    int n = 0;
    while (doneS[k] !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (doneS[k] !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL doneTimeout: dut%0d done=%b expected 1", k, doneS[k]);
    end
    @(negedge clk);
  endtask

  // Monitor: tracks sweep order and start time, then checks the scoreboard when done rises.
  initial begin
    for (int k = 0; k < 2; k++) begin
      prevBusy[k] = 1'b0;
      prevDone[k] = 1'b0;
      prevVec[k] = 6'd0;
      startCyc[k] = 0;
      stepCount[k] = 0;
      orderBad[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (busyS[k] === 1'b1 && prevBusy[k] !== 1'b1) begin
          checkOutput("startVec", 32'(vecS[k]), 0);
          startCyc[k] = cycleCount;
          stepCount[k] = 0;
          orderBad[k] = 0;
          prevVec[k] = vecS[k];
        end else if (busyS[k] === 1'b1 && vecS[k] !== prevVec[k]) begin
          if (vecS[k] === prevVec[k] + 6'd1) stepCount[k]++;
          else orderBad[k]++;
          prevVec[k] = vecS[k];
        end
        if (doneS[k] === 1'b1 && prevDone[k] !== 1'b1) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedDone: dut%0d queue size 0 required 1", k);
          end else begin
            monE = expQ.pop_front();
            checkOutput("doneId", k, monE.id);
            checkOutput("errCount", 32'(errS[k]), monE.errCount);
            checkOutput("firstFailVec", 32'(ffvS[k]), monE.ffv);
            checkOutput("firstFailY", 32'(ffyS[k]), monE.ffy);
            checkOutput("pass", 32'(passS[k]), monE.pass);
            checkOutput("busyAtDone", 32'(busyS[k]), 0);
            checkOutput("latency", cycleCount - startCyc[k], monE.latency);
            checkOutput("sweepSteps", stepCount[k], 63);
            checkOutput("sweepOrder", orderBad[k], 0);
          end
        end
        prevBusy[k] = busyS[k];
        prevDone[k] = doneS[k];
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      startS[k] = 1'b0;
      abortS[k] = 1'b0;
      faultMode[k] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstVec", 32'(vecS[0]), 0);
    checkOutput("rstBusy", 32'(busyS[0]), 0);
    checkOutput("rstDone", 32'(doneS[0]), 0);
    checkOutput("rstPass", 32'(passS[0]), 0);
    checkOutput("rstErr", 32'(errS[0]), 0);
    checkOutput("rstFfv", 32'(ffvS[0]), 0);
    checkOutput("rstFfy", 32'(ffyS[0]), 0);

    // Ideal model, default settle time.
    applyStimulus(0, 0, 1'b1, 0, 0, 0, 1, 192);
    checkOutput("busyAfterStart", 32'(busyS[0]), 1);
    waitDone(0, 400);

    // Y4 stuck-at-0, restarted from DONE.
    checkOutput("doneBeforeRestart", 32'(doneS[0]), 1);
    applyStimulus(0, 1, 1'b1, 2, 0, 7, 0, 192);
    checkOutput("restartDoneFall", 32'(doneS[0]), 0);
    checkOutput("restartBusyRise", 32'(busyS[0]), 1);
    waitDone(0, 400);

    // Y1 stuck-at-1.
    applyStimulus(0, 2, 1'b1, 48, 16, 1, 0, 192);
    waitDone(0, 400);

    // Abort during the CHECK cycle of vector 20 with Y1 stuck-at-1.
    applyStimulus(0, 2, 1'b0, 0, 0, 0, 0, 0);
    repeat (62) @(negedge clk);
    checkOutput("abortAtVec", 32'(vecS[0]), 20);
    abortS[0] = 1'b1;
    @(negedge clk);
    abortS[0] = 1'b0;
    checkOutput("abortVec", 32'(vecS[0]), 0);
    checkOutput("abortBusy", 32'(busyS[0]), 0);
    checkOutput("abortDone", 32'(doneS[0]), 0);
    checkOutput("abortErr", 32'(errS[0]), 4);
    checkOutput("abortFfv", 32'(ffvS[0]), 16);
    checkOutput("abortFfy", 32'(ffyS[0]), 1);

    // Start pulsed while busy must not disturb the run.
    applyStimulus(0, 0, 1'b1, 0, 0, 0, 1, 192);
    repeat (50) @(negedge clk);
    startS[0] = 1'b1;
    @(negedge clk);
    startS[0] = 1'b0;
    waitDone(0, 400);

    // Asynchronous reset mid-run at vector 40, then a full sweep.
    applyStimulus(0, 1, 1'b0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300 && vecS[0] !== 6'd40; n++) @(negedge clk);
    checkOutput("reachVec40", 32'(vecS[0]), 40);
    #2 rst = 1'b1;
    #1;
    checkOutput("arstVec", 32'(vecS[0]), 0);
    checkOutput("arstBusy", 32'(busyS[0]), 0);
    checkOutput("arstDone", 32'(doneS[0]), 0);
    checkOutput("arstErr", 32'(errS[0]), 0);
    checkOutput("arstFfy", 32'(ffyS[0]), 0);
    #1 rst = 1'b0;
    applyStimulus(0, 1, 1'b1, 2, 0, 7, 0, 192);
    waitDone(0, 400);

    // SETTLE_CYCLES=1: failing run, then a restart that must clear the errors.
    applyStimulus(1, 2, 1'b1, 48, 16, 1, 0, 128);
    waitDone(1, 300);
    checkOutput("s1DoneHeld", 32'(doneS[1]), 1);
    applyStimulus(1, 0, 1'b1, 0, 0, 0, 1, 128);
    checkOutput("s1RestartDone", 32'(doneS[1]), 0);
    checkOutput("s1RestartBusy", 32'(busyS[1]), 1);
    checkOutput("s1RestartErr", 32'(errS[1]), 0);
    waitDone(1, 300);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
